memory_access_unit: RTL and testbench
=====================================

Name: memory_access_unit

Overview:
Memory-access (MA) stage of the 16-bit pipeline. It sits directly upstream of writeback_unit and feeds it iswb, isld, instr, ldresult and aluresult.
- Accepts one instruction at a time from execute.
- Performs loads and stores over a req/ack data-memory port with variable latency and a timeout.
- Presents a one-cycle writeback packet to the WB stage.
- Stalls execute while a memory transaction is outstanding.

Parameters:
DATA_W, 16, data/result width
ADDR_W, 16, memory address width
TIMEOUT_CYC, 64, max cycles in a wait state before the access is abandoned (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  execute presents an instruction
in_instr  in  16  instruction word, passed through
in_aluresult  in  DATA_W  ALU result; memory address for ld/st (low ADDR_W bits)
in_stdata  in  DATA_W  store data
in_isld  in  1  load
in_isst  in  1  store
in_iswb  in  1  instruction writes a register
ma_busy  out  1  stall to execute
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  transaction complete
wb_valid  out  1  one-cycle writeback packet strobe
wb_iswb  out  1  to writeback_unit.iswb
wb_isld  out  1  to writeback_unit.isld
wb_instr  out  16  to writeback_unit.instr
wb_ldresult  out  DATA_W  to writeback_unit.ldresult
wb_aluresult  out  DATA_W  to writeback_unit.aluresult
mem_err  out  1  sticky timeout flag

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous, active-low on rst_n.
- On reset, all outputs are 0 and the state is IDLE. Reset mid-transaction drops the request immediately. An mem_ack arriving after reset is ignored.
- States:
  - IDLE, WAIT_RD, WAIT_WR.
  - ma_busy = (state != IDLE), combinational.
  - Accept condition = in_valid && state==IDLE.
- Non-memory accept (!in_isld && !in_isst):
  - Next edge registers the packet: wb_valid=1, wb_iswb=in_iswb, wb_isld=0, wb_instr, wb_aluresult.
  - wb_ldresult holds its previous value.
  - Latency is 1 cycle; back-to-back accepts are allowed.
- Load accept:
  - Next edge: state to WAIT_RD; mem_req=1, mem_we=0, mem_addr=in_aluresult[ADDR_W-1:0].
  - Latch instr, aluresult and iswb.
  - If in_isld && in_isst, the load wins and isst is ignored.
- Store accept:
  - Next edge: state to WAIT_WR; mem_req=1, mem_we=1, mem_addr and mem_wdata=in_stdata latched.
- mem_addr, mem_we and mem_wdata are held stable while mem_req=1.
- mem_ack is sampled only while mem_req=1; otherwise it is ignored.
- Ack in WAIT_RD:
  - Next edge: mem_req=0, state to IDLE.
  - Packet emitted: wb_valid=1, wb_isld=1, wb_iswb=latched iswb, wb_ldresult=mem_rdata.
- Ack in WAIT_WR:
  - Next edge: mem_req=0, state to IDLE.
  - Packet emitted with wb_iswb=0, wb_isld=0.
- Load-to-use is at least 2 cycles (ack on first req cycle). The earliest next accept is the cycle after the ack cycle, giving one bubble.
- Timeout:
  - A counter clears on entry to a WAIT state and increments each wait cycle.
  - If it reaches TIMEOUT_CYC-1 with no ack: mem_req drops, state goes to IDLE, mem_err is set (sticky until reset).
  - A packet is emitted with wb_valid=1, wb_iswb=0, wb_isld=0.
  - If ack and timeout occur in the same cycle, ack wins and there is no error.
- wb_valid, wb_iswb and wb_isld are 1-cycle pulses and are 0 in all other cycles. wb_instr, wb_aluresult and wb_ldresult hold their values between packets.

Optional Feature:
MA_STALL_CNT_EN:
- Defined: adds output port stall_cnt[15:0], which counts cycles with ma_busy=1. It saturates at 16'hFFFF and is cleared by reset.
- Undefined: no port, no counter logic.

Decomposition:
- Package cpu_pkg holds:
  - DATA_W and ADDR_W defaults.
  - Enum ma_state_t {IDLE, WAIT_RD, WAIT_WR}.
  - The wb packet struct (valid, iswb, isld, instr, ldresult, aluresult).
- One sub-module is natural: ma_timeout_ctr.
  - Inputs: clk, rst_n, clear, enable.
  - Output: expired.
  - Parameterised by TIMEOUT_CYC.

Test Plan:
1. ALU op: in_instr=16'h0100, in_aluresult=16'hABCD, in_iswb=1 -> next cycle wb_valid=1, wb_iswb=1, wb_isld=0, wb_aluresult=ABCD; no mem_req.
2. Load: in_isld=1, in_iswb=1, in_aluresult=16'h0040; ack after 3 req cycles with mem_rdata=16'h1234 -> mem_addr=0040, mem_we=0, ma_busy=1 throughout; then wb_ldresult=1234, wb_isld=1, wb_iswb=1 for one cycle.
3. Store: in_isst=1, addr 16'h0080, in_stdata=16'h5678; ack on first req cycle -> mem_we=1, mem_wdata=5678; packet with wb_iswb=0; next instruction accepted the cycle after ack.
4. Timeout with TIMEOUT_CYC=8 and no ack -> mem_req deasserts after 8 wait cycles, mem_err=1 (sticky), wb_valid=1, wb_iswb=0. Repeat with ack on cycle 8 -> no error.
5. Reset mid-load: rst_n=0 during WAIT_RD, then late ack -> all outputs 0, state IDLE, no wb_valid, mem_err=0.
6. Back-to-back ALU ops for 4 cycles (aluresult 1,2,3,4) -> four consecutive wb_valid pulses in order; with MA_STALL_CNT_EN defined, stall_cnt equals the busy cycles seen in tests 2 and 3.

Source files
------------

// File: rtl/memory_access_unit_pkg.sv
// Shared types and default widths for the CPU pipeline stages.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 16;
    localparam int INSTR_W    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WAIT_WR = 2'd2
    } ma_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  iswb;
        logic                  isld;
        logic [INSTR_W-1:0]    instr;
        logic [CPU_DATA_W-1:0] ldresult;
        logic [CPU_DATA_W-1:0] aluresult;
    } wb_pkt_t;

endpackage

// File: rtl/memory_access_unit_timeout_ctr.sv
// Wait-state watchdog: counts cycles spent waiting for a memory ack and
// flags the last permitted cycle so the caller can abandon the access.
module ma_timeout_ctr #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == LAST);

    // Restart on each new transaction, count wait cycles, park at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: passes ALU results through in one cycle,
// runs loads/stores over a req/ack port with a timeout, and emits a
// one-cycle writeback packet. Optional macro MA_STALL_CNT_EN adds a
// saturating stall_cnt output counting busy cycles.
module memory_access_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W      = CPU_DATA_W,
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [DATA_W-1:0]   in_aluresult,
    input  logic [DATA_W-1:0]   in_stdata,
    input  logic                in_isld,
    input  logic                in_isst,
    input  logic                in_iswb,
    output logic                ma_busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                wb_valid,
    output logic                wb_iswb,
    output logic                wb_isld,
    output logic [INSTR_W-1:0]  wb_instr,
    output logic [DATA_W-1:0]   wb_ldresult,
    output logic [DATA_W-1:0]   wb_aluresult,
    output logic                mem_err
`ifdef MA_STALL_CNT_EN
   ,output logic [15:0]         stall_cnt
`endif
);

    ma_state_t           state;
    logic                accept;
    logic                ack_seen;
    logic                expired;
    logic [INSTR_W-1:0]  lat_instr;
    logic [DATA_W-1:0]   lat_alu;
    logic                lat_iswb;

    assign ma_busy  = (state != IDLE);
    assign accept   = in_valid && (state == IDLE);
    assign ack_seen = mem_req && mem_ack;

    ma_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .enable  (ma_busy && mem_req),
        .expired (expired)
    );

    // Capture the instruction context of a memory op for its later packet.
    always_ff @(posedge clk) begin
        if (accept && (in_isld || in_isst)) begin
            lat_instr <= in_instr;
            lat_alu   <= in_aluresult;
            lat_iswb  <= in_iswb;
        end
    end

    // Stage FSM with registered memory-port and writeback outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_iswb      <= 1'b0;
            wb_isld      <= 1'b0;
            wb_instr     <= '0;
            wb_ldresult  <= '0;
            wb_aluresult <= '0;
            mem_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_iswb  <= 1'b0;
            wb_isld  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_isld) begin
                            state    <= WAIT_RD;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= in_aluresult[ADDR_W-1:0];
                        end else if (in_isst) begin
                            state     <= WAIT_WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= in_aluresult[ADDR_W-1:0];
                            mem_wdata <= in_stdata;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_iswb      <= in_iswb;
                            wb_instr     <= in_instr;
                            wb_aluresult <= in_aluresult;
                        end
                    end
                end
                WAIT_RD, WAIT_WR: begin
                    // An ack on the final wait cycle still completes the access.
                    if (ack_seen || expired) begin
                        state        <= IDLE;
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_instr     <= lat_instr;
                        wb_aluresult <= lat_alu;
                        if (!ack_seen) begin
                            mem_err <= 1'b1;
                        end else if (state == WAIT_RD) begin
                            wb_isld     <= 1'b1;
                            wb_iswb     <= lat_iswb;
                            wb_ldresult <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef MA_STALL_CNT_EN
    // Saturating count of cycles in which execute is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (ma_busy && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: transaction-level model plus directed tests.
module tb_memory_access_unit;
    import cpu_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_isld, in_isst, in_iswb;
    logic [15:0] in_instr, in_aluresult, in_stdata;
    logic        ma_busy, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid, wb_iswb, wb_isld, mem_err;
    logic [15:0] wb_instr, wb_ldresult, wb_aluresult;
`ifdef MA_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    memory_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_aluresult(in_aluresult), .in_stdata(in_stdata), .in_isld(in_isld),
        .in_isst(in_isst), .in_iswb(in_iswb), .ma_busy(ma_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_iswb(wb_iswb), .wb_isld(wb_isld),
        .wb_instr(wb_instr), .wb_ldresult(wb_ldresult),
        .wb_aluresult(wb_aluresult), .mem_err(mem_err)
`ifdef MA_STALL_CNT_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding access at most, a wait count,
    // and the packet the WB stage must see after each edge.
    wb_pkt_t     m_wb;
    bit          m_busy, m_rd, m_err, m_iswb;
    logic [15:0] m_addr, m_wdata, m_instr, m_alu, m_stall;
    int          m_waits;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_rd = 0; m_err = 0; m_wb = '0; m_stall = '0; m_waits = 0;
        end else begin
            if (m_busy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            m_wb.valid = 0; m_wb.iswb = 0; m_wb.isld = 0;
            if (!m_busy) begin
                if (in_valid && (in_isld || in_isst)) begin
                    m_busy = 1; m_rd = in_isld; m_addr = in_aluresult;
                    m_wdata = in_stdata; m_instr = in_instr; m_alu = in_aluresult;
                    m_iswb = in_iswb; m_waits = 0;
                end else if (in_valid) begin
                    m_wb.valid = 1; m_wb.iswb = in_iswb;
                    m_wb.instr = in_instr; m_wb.aluresult = in_aluresult;
                end
            end else if (mem_ack || m_waits == TO - 1) begin
                m_busy = 0;
                m_wb.valid = 1; m_wb.instr = m_instr; m_wb.aluresult = m_alu;
                if (!mem_ack) m_err = 1;
                else if (m_rd) begin
                    m_wb.isld = 1; m_wb.iswb = m_iswb; m_wb.ldresult = mem_rdata;
                end
            end else begin
                m_waits++;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("ma_busy", ma_busy, m_busy);
            chk("mem_req", mem_req, m_busy);
            chk("mem_err", mem_err, m_err);
            chk("wb_valid", wb_valid, m_wb.valid);
            chk("wb_iswb", wb_iswb, m_wb.iswb);
            chk("wb_isld", wb_isld, m_wb.isld);
            chk("wb_instr", wb_instr, m_wb.instr);
            chk("wb_aluresult", wb_aluresult, m_wb.aluresult);
            chk("wb_ldresult", wb_ldresult, m_wb.ldresult);
            if (m_busy) begin
                chk("mem_we", mem_we, !m_rd);
                chk("mem_addr", mem_addr, m_addr);
                if (!m_rd) chk("mem_wdata", mem_wdata, m_wdata);
            end
`ifdef MA_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_isld = 0; in_isst = 0; in_iswb = 0;
    endtask

    task automatic present(input logic ld, input logic st, input logic wb,
                           input logic [15:0] instr, input logic [15:0] alu,
                           input logic [15:0] sd);
        in_valid = 1; in_isld = ld; in_isst = st; in_iswb = wb;
        in_instr = instr; in_aluresult = alu; in_stdata = sd;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) cyc();
        rst_n = 1;
    endtask

    int n;

    initial begin
        rst_n = 0; mem_ack = 0; mem_rdata = '0;
        in_instr = '0; in_aluresult = '0; in_stdata = '0;
        idle_inputs();
        cyc();
        check_en = 1;
        do_reset(2);
        cyc();
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_err", mem_err, 0);
        chk("reset_wb_aluresult", wb_aluresult, 16'h0000);

        // ALU pass-through
        present(0, 0, 1, 16'h0100, 16'hABCD, 16'h0000);
        cyc();
        idle_inputs();
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_aluresult", wb_aluresult, 16'hABCD);
        chk("alu_mem_req", mem_req, 0);
        cyc();
        chk("alu_pulse_end", wb_valid, 0);

        // Load, ack on third request cycle
        present(1, 0, 1, 16'h2000, 16'h0040, 16'h0000);
        cyc();
        idle_inputs();
        chk("ld_mem_addr", mem_addr, 16'h0040);
        chk("ld_mem_we", mem_we, 0);
        cyc();
        cyc();
        chk("ld_busy", ma_busy, 1);
        mem_ack = 1; mem_rdata = 16'h1234;
        cyc();
        mem_ack = 0; mem_rdata = 16'h0000;
        chk("ld_wb_ldresult", wb_ldresult, 16'h1234);
        chk("ld_wb_isld", wb_isld, 1);
        chk("ld_wb_iswb", wb_iswb, 1);
        cyc();

        // Store, ack on first request cycle, next op waiting behind it
        present(0, 1, 1, 16'h3000, 16'h0080, 16'h5678);
        cyc();
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_wdata", mem_wdata, 16'h5678);
        mem_ack = 1;
        present(0, 0, 1, 16'h0500, 16'h0777, 16'h0000);
        cyc();
        mem_ack = 0;
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_iswb", wb_iswb, 0);
        chk("st_wb_aluresult", wb_aluresult, 16'h0080);
`ifdef MA_STALL_CNT_EN
        chk("stall_cnt_t2_t3", stall_cnt, 16'd4);
`endif
        cyc();
        idle_inputs();
        chk("after_st_accept", wb_aluresult, 16'h0777);
        cyc();

        // Timeout with no ack
        present(1, 0, 1, 16'h4000, 16'h0100, 16'h0000);
        cyc();
        idle_inputs();
        n = 0;
        for (int k = 0; k < 20 && mem_req; k++) begin
            n++;
            cyc();
        end
        chk("timeout_req_cycles", n, TO);
        chk("timeout_mem_err", mem_err, 1);
        chk("timeout_wb_valid", wb_valid, 1);
        chk("timeout_wb_iswb", wb_iswb, 0);
        cyc();
        chk("timeout_err_sticky", mem_err, 1);

        // Ack on the last permitted cycle wins over timeout
        do_reset(2);
        present(1, 1, 1, 16'h4100, 16'h0104, 16'h0000);
        cyc();
        idle_inputs();
        chk("ld_wins_we", mem_we, 0);
        repeat (TO - 1) cyc();
        mem_ack = 1; mem_rdata = 16'h0BEE;
        cyc();
        mem_ack = 0;
        chk("late_ack_err", mem_err, 0);
        chk("late_ack_isld", wb_isld, 1);
        chk("late_ack_ldresult", wb_ldresult, 16'h0BEE);
        cyc();

        // Reset during a load, then a stray ack
        present(1, 0, 1, 16'h6000, 16'h0200, 16'h0000);
        cyc();
        idle_inputs();
        cyc();
        rst_n = 0;
        cyc();
        rst_n = 1; mem_ack = 1; mem_rdata = 16'hDEAD;
        chk("rst_mem_req", mem_req, 0);
        cyc();
        mem_ack = 0;
        chk("rst_no_wb", wb_valid, 0);
        chk("rst_ldresult", wb_ldresult, 16'h0000);
        chk("rst_err", mem_err, 0);
        cyc();

        // Back-to-back ALU ops
        for (int i = 1; i <= 4; i++) begin
            present(0, 0, 1, 16'h0400 + 16'(i), 16'(i), 16'h0000);
            cyc();
            chk("b2b_wb_valid", wb_valid, 1);
        end
        idle_inputs();
        chk("b2b_last", wb_aluresult, 16'h0004);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
